// File: rtl/vrf_bank.sv
// Vector register file bank: byte-lane RAMs with one registered read port,
// one byte-masked write port with write-to-read bypass, and start/end group tracking.
module vrf_bank #(
    parameter int VLEN       = 16384,
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5,
    parameter int OFF_WIDTH  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    input  logic [OFF_WIDTH-1:0]    rd_off,
    input  logic                    rd_start,
    input  logic                    rd_end,
    output logic                    rd_valid,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_first,
    output logic                    rd_last,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [OFF_WIDTH-1:0]    wr_off,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    input  logic                    wr_start,
    input  logic                    wr_end,
    output logic                    wr_done,
    output logic                    rd_busy,
    output logic                    wr_busy,
    output logic                    proto_err
);
    localparam int DEPTH = VLEN / DATA_WIDTH;
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int WORDS = (2 ** ADDR_WIDTH) * DEPTH;
    localparam int IDX_W = $clog2(WORDS);
    localparam logic [OFF_WIDTH:0] DEPTH_LIM = (OFF_WIDTH + 1)'(DEPTH);

    typedef enum logic {IDLE = 1'b0, OPEN = 1'b1} grp_state_t;

    logic [IDX_W-1:0]      rd_idx;
    logic [IDX_W-1:0]      wr_idx;
    logic                  rd_oor;
    logic                  wr_oor;
    logic                  wr_do;
    logic                  bypass;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [1:0]            grp_en;
    logic [1:0]            grp_start;
    logic [1:0]            grp_end;
    logic [1:0]            grp_busy;
    logic [1:0]            seq_err;

    assign rd_idx = IDX_W'(rd_addr) * IDX_W'(DEPTH) + IDX_W'(rd_off);
    assign wr_idx = IDX_W'(wr_addr) * IDX_W'(DEPTH) + IDX_W'(wr_off);
    assign rd_oor = {1'b0, rd_off} >= DEPTH_LIM;
    assign wr_oor = {1'b0, wr_off} >= DEPTH_LIM;
    assign wr_do  = wr_en & ~wr_oor;
    assign bypass = rd_en & wr_do & (rd_idx == wr_idx);

    // One RAM per byte lane so the byte enable is a plain per-lane write enable.
    // Storage is never cleared; a write presented while rst is high is discarded.
    genvar gi;
    generate
        for (gi = 0; gi < BYTES; gi++) begin : g_lane
            logic [7:0] mem [WORDS];

            always_ff @(posedge clk or posedge rst) begin
                if (!rst && wr_do && wr_be[gi]) begin
                    mem[wr_idx] <= wr_data[8*gi +: 8];
                end
            end

            assign rd_word[8*gi +: 8] = (bypass && wr_be[gi]) ? wr_data[8*gi +: 8] : mem[rd_idx];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_first <= 1'b0;
            rd_last  <= 1'b0;
            wr_done  <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            rd_first <= rd_en & rd_start;
            rd_last  <= rd_en & rd_end;
            wr_done  <= wr_en & wr_end;
            if (rd_en) begin
                rd_data <= rd_oor ? '0 : rd_word;
            end
        end
    end

    // Port 0 is the read group, port 1 the write group.
    assign grp_en    = {wr_en, rd_en};
    assign grp_start = {wr_start, rd_start};
    assign grp_end   = {wr_end, rd_end};

    generate
        for (gi = 0; gi < 2; gi++) begin : g_grp
            grp_state_t state_reg;
            grp_state_t state_next;
            logic       busy;
            logic       err;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state_reg <= IDLE;
                end else begin
                    state_reg <= state_next;
                end
            end

            always_comb begin
                state_next = state_reg;
                if (grp_en[gi]) begin
                    if (grp_start[gi]) begin
                        state_next = grp_end[gi] ? IDLE : OPEN;
                    end else if (state_reg == OPEN && grp_end[gi]) begin
                        state_next = IDLE;
                    end
                end
            end

            always_comb begin
                busy = (state_reg == OPEN);
                err  = grp_en[gi] & ((state_reg == OPEN) ? grp_start[gi] : ~grp_start[gi]);
            end

            assign grp_busy[gi] = busy;
            assign seq_err[gi]  = err;
        end
    endgenerate

    assign rd_busy = grp_busy[0];
    assign wr_busy = grp_busy[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            proto_err <= 1'b0;
        end else begin
            proto_err <= proto_err | (|seq_err) | (rd_en & rd_oor) | (wr_en & wr_oor);
        end
    end
endmodule
